// File: rtl/apple1_pkg.sv
// Shared constants and state encoding for the Apple-1 text-load replay path.
package apple1_pkg;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_WAIT,
        S_FILTER,
        S_PRESENT,
        S_GAP,
        S_FINISH
    } feeder_state_t;

endpackage

// File: rtl/apple1_char_filter.sv
// Maps one text-buffer byte to an Apple-1 keystroke: uppercase, CR/LF folding,
// dropping of unprintables, and NUL as end of file.
module apple1_char_filter
    import apple1_pkg::*;
(
    input  logic [7:0] char_in,
    input  logic       prev_was_cr,
    output logic       emit,
    output logic [6:0] char_out,
    output logic       eof
);

    always_comb begin
        emit     = 1'b0;
        eof      = 1'b0;
        char_out = char_in[6:0];
        if (char_in == ASCII_NUL) begin
            eof = 1'b1;
        end else if (char_in == ASCII_CR) begin
            emit = 1'b1;
        end else if (char_in == ASCII_LF) begin
            // an LF directly after a CR belongs to the same line ending
            emit     = !prev_was_cr;
            char_out = ASCII_CR[6:0];
        end else if (char_in >= 8'h61 && char_in <= 8'h7A) begin
            emit     = 1'b1;
            char_out = char_in[6:0] - 7'h20;
        end else if ((char_in >= 8'h20 && char_in <= 8'h60) ||
                     (char_in >= 8'h7B && char_in <= 8'h7E)) begin
            emit = 1'b1;
        end
    end

endmodule

// File: rtl/apple1_text_feeder.sv
// Replays a downloaded text buffer into the Apple-1 keyboard port, one
// keystroke per CPU read, with idle gaps so the monitor/BASIC can keep up.
module apple1_text_feeder
    import apple1_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int CHAR_GAP = 25000,
    parameter int LINE_GAP = 2500000
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_data,
    output logic [6:0]        kbd_data,
    output logic              kbd_valid,
    input  logic              kbd_ack,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W = $clog2(LINE_GAP + 1);

    feeder_state_t     state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   wr_end;
    logic [GAP_W-1:0]  gap_cnt;
    logic              dl_active_q;
    logic              dl_rise;
    logic              dl_fall;
    logic              prev_was_cr;
    logic              filt_emit;
    logic              filt_eof;
    logic [6:0]        filt_char;

    assign dl_rise = dl_active && !dl_active_q;
    assign dl_fall = !dl_active && dl_active_q;
    assign wr_end  = {1'b0, dl_addr} + (ADDR_W + 1)'(1);

    apple1_char_filter u_filter (
        .char_in     (buf_data),
        .prev_was_cr (prev_was_cr),
        .emit        (filt_emit),
        .char_out    (filt_char),
        .eof         (filt_eof)
    );

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) dl_active_q <= 1'b0;
        else        dl_active_q <= dl_active;
    end

    // len tracks the highest written address + 1, so out-of-order writes still count
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
        end else if (dl_rise) begin
            len <= dl_wr ? wr_end : '0;
        end else if (dl_active && dl_wr && wr_end > len) begin
            len <= wr_end;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gap_cnt     <= '0;
            buf_addr    <= '0;
            kbd_data    <= '0;
            kbd_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            prev_was_cr <= 1'b0;
        end else begin
            done <= 1'b0;
            if (dl_rise && state != S_IDLE) begin
                // a new download aborts the replay in progress
                kbd_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= S_LOAD;
            end else begin
                case (state)
                    S_IDLE: if (dl_rise) state <= S_LOAD;
                    S_LOAD: begin
                        if (dl_fall) begin
                            if (len == '0) begin
                                state <= S_IDLE;
                            end else begin
                                ptr         <= '0;
                                prev_was_cr <= 1'b0;
                                busy        <= 1'b1;
                                state       <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (ptr == len) begin
                            state <= S_FINISH;
                        end else begin
                            buf_addr <= ptr[ADDR_W-1:0];
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: state <= S_FILTER;
                    S_FILTER: begin
                        ptr <= ptr + (ADDR_W + 1)'(1);
                        if (filt_eof) begin
                            state <= S_FINISH;
                        end else if (filt_emit) begin
                            kbd_data    <= filt_char;
                            kbd_valid   <= 1'b1;
                            prev_was_cr <= (filt_char == ASCII_CR[6:0]);
                            state       <= S_PRESENT;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                    S_PRESENT: begin
                        if (kbd_ack) begin
                            kbd_valid <= 1'b0;
                            gap_cnt   <= (kbd_data == ASCII_CR[6:0]) ? GAP_W'(LINE_GAP)
                                                                      : GAP_W'(CHAR_GAP);
                            state     <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) state <= S_FETCH;
                        else               gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                    S_FINISH: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apple1_text_feeder.sv
// Directed plus randomized replay checks for apple1_text_feeder against a
// queue-based model of the text-to-keystroke rules.
module tb_apple1_text_feeder;

    localparam int ADDR_W     = 13;
    localparam int CHAR_GAP_T = 6;
    localparam int LINE_GAP_T = 30;

    logic              clk25 = 1'b0;
    logic              rst_n;
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic [6:0]        kbd_data;
    logic              kbd_valid;
    logic              kbd_ack;
    logic              busy;
    logic              done;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    byte unsigned text_q[$];
    byte unsigned exp_q[$];
    int           src_q[$];
    int           end_idx;
    int           last_read;
    int           max_addr;
    logic [ADDR_W-1:0] prev_addr = '0;

    apple1_text_feeder #(
        .ADDR_W   (ADDR_W),
        .CHAR_GAP (CHAR_GAP_T),
        .LINE_GAP (LINE_GAP_T)
    ) dut (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ack   (kbd_ack),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk25 = ~clk25;

    // synchronous-read text buffer: data valid one cycle after the address
    always @(posedge clk25) buf_data <= mem[buf_addr];

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_range(input string tag, input int observed, input int lo, input int hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk25);
        if (busy && buf_addr != prev_addr && int'(buf_addr) > max_addr) max_addr = int'(buf_addr);
        prev_addr = buf_addr;
    endtask

    // keystroke model: what the Apple-1 should see for the current text_q
    function automatic void build_expected();
        bit prev_cr = 1'b0;
        byte unsigned b;
        byte unsigned c;
        bit keep;
        exp_q.delete();
        src_q.delete();
        end_idx   = text_q.size();
        last_read = text_q.size() - 1;
        for (int i = 0; i < text_q.size(); i++) begin
            b = text_q[i];
            if (b == 8'h00) begin
                end_idx   = i;
                last_read = i;
                break;
            end
            keep = 1'b1;
            c    = b;
            if (b == 8'h0A) begin
                c    = 8'h0D;
                keep = !prev_cr;
            end else if (b >= 8'h61 && b <= 8'h7A) begin
                c = b - 8'h20;
            end else if (b != 8'h0D && !((b >= 8'h20 && b <= 8'h60) || (b >= 8'h7B && b <= 8'h7E))) begin
                keep = 1'b0;
            end
            if (keep) begin
                exp_q.push_back(c);
                src_q.push_back(i);
                prev_cr = (c == 8'h0D);
            end
        end
    endfunction

    task automatic set_text(input string s);
        text_q.delete();
        for (int i = 0; i < s.len(); i++) text_q.push_back(s[i]);
    endtask

    task automatic make_random_text(input int n);
        text_q.delete();
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
                5:       text_q.push_back(8'h0D);
                6:       text_q.push_back(8'h0A);
                7:       text_q.push_back(8'($urandom_range(1, 31)));
                8:       text_q.push_back(8'($urandom_range(8'h7F, 8'hFF)));
                9:       text_q.push_back(8'($urandom_range(8'h61, 8'h7A)));
                default: text_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
            endcase
        end
    endtask

    // writes text_q while dl_active is already high, then releases dl_active
    task automatic write_text(input bit reverse);
        int a;
        for (int i = 0; i < text_q.size(); i++) begin
            a = reverse ? text_q.size() - 1 - i : i;
            mem[a]  = text_q[a];
            dl_addr = ADDR_W'(a);
            dl_wr   = 1'b1;
            tick();
            dl_wr   = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        dl_active = 1'b0;
    endtask

    task automatic apply_stimulus(input bit reverse);
        dl_active = 1'b1;
        tick();
        write_text(reverse);
    endtask

    task automatic run_replay(input string name, input int abort_at, input bit check_lat);
        int got = 0;
        int k;
        int n;
        int gap_n;
        int span;
        bit stable;
        byte unsigned cur;
        build_expected();
        max_addr = 0;
        k = 0;
        while (!kbd_valid && !done && k < 500) begin tick(); k++; end
        if (check_lat) check_output($sformatf("%s_latency", name), k, 4);
        forever begin
            if (done) break;
            if (!kbd_valid) begin
                check_output($sformatf("%s_timeout", name), kbd_valid, 1);
                return;
            end
            check_output($sformatf("%s_busy", name), busy, 1);
            if (got >= exp_q.size()) begin
                check_output($sformatf("%s_extra_char", name), got + 1, exp_q.size());
                return;
            end
            cur = exp_q[got];
            check_output($sformatf("%s_char%0d", name, got), kbd_data, cur);
            if (got == abort_at) begin
                dl_active = 1'b1;
                tick();
                check_output($sformatf("%s_abort_valid", name), kbd_valid, 0);
                check_output($sformatf("%s_abort_done", name), done, 1);
                check_output($sformatf("%s_abort_busy", name), busy, 0);
                return;
            end
            n = $urandom_range(0, 3);
            stable = 1'b1;
            repeat (n) begin
                tick();
                if (kbd_valid !== 1'b1 || kbd_data !== cur[6:0]) stable = 1'b0;
            end
            check_output($sformatf("%s_hold%0d", name, got), stable, 1);
            kbd_ack = 1'b1;
            tick();
            kbd_ack = 1'b0;
            check_output($sformatf("%s_ack_drop%0d", name, got), kbd_valid, 0);
            gap_n = (cur == 8'h0D) ? LINE_GAP_T : CHAR_GAP_T;
            span  = ((got + 1 < src_q.size()) ? src_q[got + 1] : end_idx) - src_q[got] - 1;
            got++;
            k = 0;
            while (!kbd_valid && !done && k < LINE_GAP_T + 500) begin tick(); k++; end
            check_range($sformatf("%s_gap%0d", name, got), k, gap_n + 1, gap_n + 8 + 3 * span);
        end
        check_output($sformatf("%s_count", name), got, exp_q.size());
        check_output($sformatf("%s_busy_end", name), busy, 0);
        tick();
        check_output($sformatf("%s_done_pulse", name), done, 0);
        check_range($sformatf("%s_addr_bound", name), max_addr, 0, last_read);
    endtask

    initial begin
        bit saw_busy;
        bit saw_done;
        bit stable;
        logic [6:0] held;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h5A;
        rst_n     = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        kbd_ack   = 1'b0;
        max_addr  = 0;
        repeat (3) tick();
        check_output("reset_buf_addr", buf_addr, 0);
        check_output("reset_kbd_data", kbd_data, 0);
        check_output("reset_kbd_valid", kbd_valid, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] A<CR> replay");
        text_q.delete();
        text_q.push_back(8'h41);
        text_q.push_back(8'h0D);
        apply_stimulus(1'b0);
        run_replay("a_cr", -1, 1'b1);

        $display("[TB] lowercase line with CRLF");
        set_text("print 1");
        text_q.push_back(8'h0D);
        text_q.push_back(8'h0A);
        apply_stimulus(1'b1);
        run_replay("crlf", -1, 1'b1);

        $display("[TB] unprintable bytes dropped");
        text_q.delete();
        text_q.push_back(8'h09);
        text_q.push_back(8'h7F);
        text_q.push_back(8'hC1);
        text_q.push_back(8'h42);
        apply_stimulus(1'b0);
        run_replay("drop", -1, 1'b0);

        $display("[TB] NUL terminates replay");
        set_text("AB");
        text_q.push_back(8'h00);
        text_q.push_back(8'h43);
        text_q.push_back(8'h44);
        apply_stimulus(1'b0);
        run_replay("eof", -1, 1'b1);

        $display("[TB] printable range boundaries");
        set_text("`az{~ ");
        text_q.push_back(8'h1F);
        text_q.push_back(8'h0A);
        text_q.push_back(8'h0A);
        apply_stimulus(1'b1);
        run_replay("bounds", -1, 1'b1);

        $display("[TB] abort by new download");
        set_text("xyzw");
        text_q.push_back(8'h0D);
        apply_stimulus(1'b0);
        run_replay("abort", 2, 1'b1);
        set_text("new 9");
        text_q.push_back(8'h0D);
        write_text(1'b0);
        run_replay("after_abort", -1, 1'b1);

        $display("[TB] empty download");
        dl_active = 1'b1;
        repeat (3) tick();
        dl_active = 1'b0;
        saw_busy = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            tick();
            if (busy) saw_busy = 1'b1;
            if (done) saw_done = 1'b1;
        end
        check_output("empty_busy", saw_busy, 0);
        check_output("empty_done", saw_done, 0);

        $display("[TB] randomized texts");
        for (int t = 0; t < 6; t++) begin
            make_random_text($urandom_range(5, 20));
            apply_stimulus(1'($urandom_range(0, 1)));
            run_replay($sformatf("rand%0d", t), -1, 1'b0);
        end

        $display("[TB] long ack stall then async reset");
        set_text("hi");
        apply_stimulus(1'b0);
        begin
            int k = 0;
            while (!kbd_valid && k < 100) begin tick(); k++; end
        end
        check_output("stall_valid", kbd_valid, 1);
        held   = kbd_data;
        check_output("stall_char", held, 8'h48);
        stable = 1'b1;
        repeat (2000) begin
            tick();
            if (kbd_valid !== 1'b1 || kbd_data !== held) stable = 1'b0;
        end
        check_output("stall_stable", stable, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_buf_addr", buf_addr, 0);
        check_output("async_kbd_data", kbd_data, 0);
        check_output("async_kbd_valid", kbd_valid, 0);
        check_output("async_busy", busy, 0);
        check_output("async_done", done, 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_output("no_resume_valid", kbd_valid, 0);
        check_output("no_resume_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
